add8_share_ctrl: RTL and testbench
==================================

// Module: add8_share_ctrl
// PURPOSE
// - Shares one 8-bit approximate adder instance among NUM_REQ requesters.
// - Round-robin arbitration, a registered operand stage and a registered result stage.
// - Each response carries the id of the requester that issued it.
// - Sits between the requesting datapath lanes and the single external adder instance (A,B -> O[8:0]).
// PARAMETERS
// - NUM_REQ  4  number of requesters, 2..8
// - ID_W     2  requester id width, = clog2(NUM_REQ)
// PORTS
// - clk        in   1          rising-edge clock
// - rst_n      in   1          asynchronous reset, active-low
// - ctrl_en    in   1          1 = grants allowed; 0 = drain in-flight work, then idle
// - req_valid  in   NUM_REQ    per-requester operand valid
// - req_a      in   8*NUM_REQ  operand A, requester i at [8i+7:8i]
// - req_b      in   8*NUM_REQ  operand B, same packing
// - req_ready  out  NUM_REQ    one-hot accept; a transfer happens when valid&ready
// - add_a      out  8          to shared adder input A (registered)
// - add_b      out  8          to shared adder input B (registered)
// - add_o      in   9          from shared adder output O, combinational w.r.t. add_a/add_b
// - rsp_valid  out  1          result valid
// - rsp_ready  in   1          result accept
// - rsp_sum    out  9          registered adder result
// - rsp_id     out  ID_W       requester id of rsp_sum
// - rsp_sat    out  1          saturation flag (see CONFIGURATION)
// - idle       out  1          1 when FSM is in IDLE and both stages are empty
// BEHAVIOUR
// - Reset values: req_ready=0, add_a=0, add_b=0, rsp_valid=0, rsp_sum=0, rsp_id=0, rsp_sat=0, idle=1.
// - Round-robin pointer resets to 0.
// - FSM has three states:
//   - IDLE:  ctrl_en=1 -> RUN.
//   - RUN:   ctrl_en=0 -> DRAIN.
//   - DRAIN: both stages empty -> IDLE; ctrl_en=1 -> RUN.
// - Grant only in RUN, and only when stage 1 is empty or advances this cycle.
// - req_ready is one-hot or zero, and is a combinational function of req_valid, the pointer, state and the stall condition.
// - Arbitration: the first valid requester at or after the pointer, modulo NUM_REQ.
// - After a grant to requester k, the pointer moves to k+1, wrapping at NUM_REQ-1 -> 0.
// - With no grant, the pointer holds.
// - Stage 1 (operand): captures req_a/req_b/id on accept; add_a/add_b are driven directly from stage 1.
// - Stage 2 (result): captures add_o and the id from stage 1.
// - Latency: accept in cycle t -> rsp_valid=1 in cycle t+2 when there is no backpressure.
// - Stall: stage 2 holds while rsp_valid & ~rsp_ready.
//   - Stage 1 holds while it is valid and stage 2 is stalled.
//   - A full pipeline under stall accepts nothing.
// - Throughput: one operation per cycle with rsp_ready=1.
// - Accept and retire may occur in the same cycle, and the pipeline advances.
// - No operation is dropped or duplicated under any valid/ready pattern.
// - ctrl_en falling while ops are in flight: no new grants; in-flight ops complete normally.
// - A grant in the same cycle that ctrl_en falls is not allowed, because the state is still RUN and ready is gated on ctrl_en.
// - Asynchronous reset mid-operation discards all in-flight ops and returns every output to its reset value.
// - Arithmetic: the controller never modifies add_o except under ADD8_SAT_EN.
// - The controller never corrects approximation error.
// CONFIGURATION
// - ADD8_SAT_EN defined:
//   - When add_o[8]=1, stage 2 stores rsp_sum=9'h0FF and rsp_sat=1.
//   - Otherwise it stores add_o with rsp_sat=0.
// - ADD8_SAT_EN undefined: rsp_sum = add_o unchanged, and rsp_sat is a constant 0.
// STRUCTURE
// - Shared package add8_share_pkg holds:
//   - state enum {IDLE, RUN, DRAIN};
//   - the localparam for the operand width (8) and result width (9);
//   - the function clog2 for the id width.
// - One sub-module: add8_rr_arb (NUM_REQ req vector, advance strobe -> one-hot grant, grant index, pointer).
// - The pipeline stages and the FSM live in add8_share_ctrl.
// - The adder is external, connected through add_a/add_b/add_o.
// TESTING (bench drives add_o from an exact 9-bit sum model of add_a+add_b)
// - Single request: req0 a=8'd200, b=8'd100, rsp_ready=1.
//   -> rsp_valid two cycles after accept, rsp_sum=9'h12C, rsp_id=0; rsp_sat=1 and sum 9'h0FF under ADD8_SAT_EN.
// - All 4 requesters valid continuously, rsp_ready=1.
//   -> grants in order 0,1,2,3,0,...; one response per cycle; ids match the grant order.
// - Backpressure: hold rsp_ready=0 for 5 cycles with all requesters valid.
//   -> exactly 2 ops in flight; req_ready=0 throughout; release yields in-order responses with no loss.
// - ctrl_en drops with 2 ops in flight -> FSM goes to DRAIN, both responses delivered, then idle=1, and no further grants.
// - rst_n asserted with a full pipeline -> rsp_valid=0 immediately; after release, the first grant goes to requester 0.
// - Random valid/ready traffic for 10k cycles -> scoreboard shows every accepted (id,a,b) answered once, in order, with the correct sum.

Source files
------------

// File: rtl/add8_share_pkg.sv
// Shared state encoding, datapath widths and id-width helper for the add8 sharing controller.
package add8_share_pkg;

  localparam int OP_W  = 8;
  localparam int RES_W = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/add8_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first request at or after the pointer, same cycle.
// Pointer moves past the winner only when adv_i confirms the transfer; otherwise it holds.
module add8_rr_arb
  import add8_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               en_i,
  input  logic               adv_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_idx_o
);

  localparam int CW = ID_W + 1;

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [CW-1:0]   cand;
  logic            found;

  // Walk the requesters starting at the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + CW'(i);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      if (!found && en_i && req_i[cand[ID_W-1:0]]) begin
        found                   = 1'b1;
        gnt_o[cand[ID_W-1:0]]   = 1'b1;
        gnt_idx_o               = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) begin
      ptr_d = (gnt_idx_o == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx_o + ID_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/add8_share_ctrl.sv
// Shares one external 8-bit adder among NUM_REQ requesters; ADD8_SAT_EN clamps carry-out results to 9'h0FF.
// Accept -> response in 2 cycles; a stalled result stage freezes the operand stage and blocks grants.
module add8_share_ctrl
  import add8_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ctrl_en,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [OP_W*NUM_REQ-1:0] req_a,
  input  logic [OP_W*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [OP_W-1:0]         add_a,
  output logic [OP_W-1:0]         add_b,
  input  logic [RES_W-1:0]        add_o,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [RES_W-1:0]        rsp_sum,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    rsp_sat,
  output logic                    idle
);

  state_e state_q;

  logic             s1_vld_q, s1_vld_d;
  logic [OP_W-1:0]  s1_a_q, s1_a_d;
  logic [OP_W-1:0]  s1_b_q, s1_b_d;
  logic [ID_W-1:0]  s1_id_q, s1_id_d;
  logic             s2_vld_q, s2_vld_d;
  logic [RES_W-1:0] s2_sum_q, s2_sum_d;
  logic [ID_W-1:0]  s2_id_q, s2_id_d;

  logic               s2_stall, s1_adv, grant_en, accept;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic [OP_W-1:0]    sel_a, sel_b;
  logic [RES_W-1:0]   res_sum;
  logic               res_sat;

  assign s2_stall = s2_vld_q & ~rsp_ready;
  assign s1_adv   = s1_vld_q & ~s2_stall;
  // Operand stage is free if empty or moving on this cycle; ctrl_en gates same-cycle grants.
  assign grant_en = (state_q == RUN) & ctrl_en & (~s1_vld_q | s1_adv);
  assign accept   = |gnt;

  add8_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_valid),
    .en_i      (grant_en),
    .adv_i     (accept),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_a = req_a[OP_W*i +: OP_W];
        sel_b = req_b[OP_W*i +: OP_W];
      end
    end
  end

`ifdef ADD8_SAT_EN
  assign res_sat = add_o[RES_W-1];
  assign res_sum = res_sat ? RES_W'(9'h0FF) : add_o;
`else
  assign res_sat = 1'b0;
  assign res_sum = add_o;
`endif

  always_comb begin
    s1_vld_d = s1_vld_q;
    s1_a_d   = s1_a_q;
    s1_b_d   = s1_b_q;
    s1_id_d  = s1_id_q;
    if (accept) begin
      s1_vld_d = 1'b1;
      s1_a_d   = sel_a;
      s1_b_d   = sel_b;
      s1_id_d  = gnt_idx;
    end else if (s1_adv) begin
      s1_vld_d = 1'b0;
    end

    s2_vld_d = s2_vld_q;
    s2_sum_d = s2_sum_q;
    s2_id_d  = s2_id_q;
    if (s1_adv) begin
      s2_vld_d = 1'b1;
      s2_sum_d = res_sum;
      s2_id_d  = s1_id_q;
    end else if (rsp_ready) begin
      s2_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_id_q  <= '0;
      s2_vld_q <= 1'b0;
      s2_sum_q <= '0;
      s2_id_q  <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_a_q   <= s1_a_d;
      s1_b_q   <= s1_b_d;
      s1_id_q  <= s1_id_d;
      s2_vld_q <= s2_vld_d;
      s2_sum_q <= s2_sum_d;
      s2_id_q  <= s2_id_d;
    end
  end

`ifdef ADD8_SAT_EN
  logic s2_sat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      s2_sat_q <= 1'b0;
    else if (s1_adv) s2_sat_q <= res_sat;
  end

  assign rsp_sat = s2_sat_q;
`else
  assign rsp_sat = res_sat;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (ctrl_en) state_q <= RUN;
        RUN:     if (!ctrl_en) state_q <= DRAIN;
        DRAIN: begin
          if (ctrl_en)                     state_q <= RUN;
          else if (!s1_vld_q && !s2_vld_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = gnt;
  assign add_a     = s1_a_q;
  assign add_b     = s1_b_q;
  assign rsp_valid = s2_vld_q;
  assign rsp_sum   = s2_sum_q;
  assign rsp_id    = s2_id_q;
  assign idle      = (state_q == IDLE) & ~s1_vld_q & ~s2_vld_q;

endmodule

// File: tb/tb_add8_share_ctrl.sv
// Directed and random bench for add8_share_ctrl with an exact-sum adder model on add_a/add_b.
`timescale 1ns/1ps
module tb_add8_share_ctrl;

  localparam int N  = 4;
  localparam int IW = 2;
`ifdef ADD8_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           ctrl_en;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_a, req_b;
  logic [N-1:0]   req_ready;
  logic [7:0]     add_a, add_b;
  logic [8:0]     add_o;
  logic           rsp_valid, rsp_ready;
  logic [8:0]     rsp_sum;
  logic [IW-1:0]  rsp_id;
  logic           rsp_sat, idle;

  add8_share_ctrl #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .ctrl_en(ctrl_en),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .add_a(add_a), .add_b(add_b), .add_o(add_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
    .rsp_id(rsp_id), .rsp_sat(rsp_sat), .idle(idle)
  );

  always #5 clk = ~clk;

  assign add_o = {1'b0, add_a} + {1'b0, add_b};

  typedef struct packed {
    logic [IW-1:0] id;
    logic [7:0]    a;
    logic [7:0]    b;
  } op_t;

  op_t sb[$];
  int  gnt_log[$];
  int  n_acc = 0, n_ret = 0, n_drop = 0;
  int  checks = 0, errors = 0;
  int  acc0, ret0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] exp_sum(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (SAT_EN && s[8]) s = 9'h0FF;
    return s;
  endfunction

  function automatic logic exp_sat(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return SAT_EN && s[8];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transfers are observed mid-cycle; in-order scoreboard against the exact-sum model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("rdy_onehot", 32'($onehot0(req_ready)), 32'd1);
      chk("rdy_without_valid", 32'(|(req_ready & ~req_valid)), 32'd0);
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb.push_back('{id: IW'(i), a: req_a[8*i +: 8], b: req_b[8*i +: 8]});
          gnt_log.push_back(i);
          n_acc++;
        end
      end
      if (rsp_valid && rsp_ready) begin
        n_ret++;
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          op_t o;
          o = sb.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(o.id));
          chk("rsp_sum", 32'(rsp_sum), 32'(exp_sum(o.a, o.b)));
          chk("rsp_sat", 32'(rsp_sat), 32'(exp_sat(o.a, o.b)));
        end
      end
    end
  end

  initial begin
    req_valid = '0; req_a = '0; req_b = '0;
    rsp_ready = 1'b1; ctrl_en = 1'b0;

    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_add_a", 32'(add_a), 32'd0);
    chk("rst_add_b", 32'(add_b), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_sum", 32'(rsp_sum), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_sat", 32'(rsp_sat), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);

    @(posedge clk); #1;
    rst_n = 1'b1; ctrl_en = 1'b1;
    tick();

    // Single request 200 + 100.
    req_a[7:0] = 8'd200; req_b[7:0] = 8'd100; req_valid = 4'b0001;
    #1 chk("single_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = '0;
    chk("single_t1_valid", 32'(rsp_valid), 32'd0);
    chk("single_add_a", 32'(add_a), 32'd200);
    chk("single_add_b", 32'(add_b), 32'd100);
    tick();
    chk("single_t2_valid", 32'(rsp_valid), 32'd1);
    chk("single_sum", 32'(rsp_sum), SAT_EN ? 32'h0FF : 32'h12C);
    chk("single_id", 32'(rsp_id), 32'd0);
    chk("single_sat", 32'(rsp_sat), 32'(SAT_EN));
    tick();
    chk("single_t3_valid", 32'(rsp_valid), 32'd0);

    // All requesters streaming; pointer sits at 1 after the single grant to 0.
    gnt_log.delete(); ret0 = n_ret;
    req_a = {8'd40, 8'd30, 8'd20, 8'd10};
    req_b = {8'd250, 8'd7, 8'd128, 8'd1};
    req_valid = 4'hF;
    for (int k = 0; k < 12; k++) begin
      #1 chk("rr_ready", 32'(req_ready), 32'd1 << ((1 + k) % 4));
      if (k >= 2) chk("stream_valid", 32'(rsp_valid), 32'd1);
      tick();
    end
    req_valid = '0;
    chk("rr_count", 32'(gnt_log.size()), 32'd12);
    for (int k = 0; k < 12; k++) chk("rr_order", 32'(gnt_log[k]), 32'((1 + k) % 4));
    repeat (3) tick();
    chk("stream_retired", 32'(n_ret - ret0), 32'd12);

    // Backpressure: two ops fill the pipe, then nothing more is accepted.
    gnt_log.delete(); acc0 = n_acc; ret0 = n_ret;
    rsp_ready = 1'b0; req_valid = 4'hF;
    tick(); tick();
    for (int k = 0; k < 5; k++) begin
      #1 chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_id_hold", 32'(rsp_id), 32'd1);
      tick();
    end
    chk("bp_in_flight", 32'(n_acc - acc0), 32'd2);
    chk("bp_first", 32'(gnt_log[0]), 32'd1);
    chk("bp_second", 32'(gnt_log[1]), 32'd2);
    req_valid = '0; rsp_ready = 1'b1;
    repeat (3) tick();
    chk("bp_retired", 32'(n_ret - ret0), 32'd2);

    // ctrl_en drops with two ops in flight.
    gnt_log.delete(); acc0 = n_acc; ret0 = n_ret;
    req_valid = 4'hF;
    tick(); tick();
    ctrl_en = 1'b0;
    #1 chk("drain_ready_now", 32'(req_ready), 32'd0);
    chk("drain_busy0", 32'(idle), 32'd0);
    tick();
    chk("drain_busy1", 32'(idle), 32'd0);
    chk("drain_ready1", 32'(req_ready), 32'd0);
    tick();
    chk("drain_ready2", 32'(req_ready), 32'd0);
    tick();
    chk("drain_idle", 32'(idle), 32'd1);
    for (int k = 0; k < 3; k++) begin
      chk("drain_no_grant", 32'(req_ready), 32'd0);
      tick();
    end
    chk("drain_acc", 32'(n_acc - acc0), 32'd2);
    chk("drain_ret", 32'(n_ret - ret0), 32'd2);
    chk("drain_ids0", 32'(gnt_log[0]), 32'd3);
    chk("drain_ids1", 32'(gnt_log[1]), 32'd0);

    // Reset with a full, stalled pipeline.
    ctrl_en = 1'b1; req_valid = '0;
    tick();
    rsp_ready = 1'b0; req_valid = 4'hF;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1 chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_idle", 32'(idle), 32'd1);
    chk("mid_rst_add_a", 32'(add_a), 32'd0);
    chk("mid_rst_sum", 32'(rsp_sum), 32'd0);
    n_drop += sb.size();
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1; rsp_ready = 1'b1;
    #1 chk("post_rst_idle_ready", 32'(req_ready), 32'd0);
    tick();
    chk("post_rst_first_grant", 32'(req_ready), 32'd1);

    // Random traffic.
    acc0 = n_acc;
    for (int c = 0; c < 10000; c++) begin
      req_valid = 4'($urandom_range(0, 15));
      req_a     = $urandom;
      req_b     = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      ctrl_en   = ($urandom_range(0, 31) != 0);
      tick();
    end
    req_valid = '0; ctrl_en = 1'b1; rsp_ready = 1'b1;
    repeat (4) tick();
    chk("rand_traffic", 32'(n_acc - acc0 > 1000), 32'd1);
    chk("rand_sb_empty", 32'(sb.size()), 32'd0);
    chk("rand_balance", 32'(n_acc), 32'(n_ret + n_drop));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
